reg_write_ctrl: RTL

Write-side front end for the 4-entry × 64-bit `register_file`. It accepts write requests over a valid/ready stream and buffers them in a 4-deep FIFO. It drives the register file's single write port one request at a time, then reads the just-written entry back and compares it against the written data. It reports per-write completion, plus a sticky error with the failing address.

---
 rtl/reg_wr_pkg.sv | 21 ++
 rtl/register_file.sv | 31 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/reg_write_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/reg_wr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wr_pkg
//  Description : Shared defaults and FSM state encoding for the register
//                file write-side front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_wr_pkg;

    localparam int c_DATA_W     = 64;
    localparam int c_ADDR_W     = 2;
    localparam int c_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

endpackage : reg_wr_pkg
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : Small register file with one synchronous write port and a
//                combinational read of the same address.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              i_write_en,
    input  logic [ADDR_W-1:0] i_addr_1,
    input  logic [DATA_W-1:0] i_data_in,
    output logic [DATA_W-1:0] o_data_out
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    assign o_data_out = r_mem[i_addr_1];

    // Capture write data at the end of a write-enabled cycle
    always_ff @(posedge clk) begin
        if (i_write_en) begin
            r_mem[i_addr_1] <= i_data_in;
        end
    end

endmodule : register_file
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. Pointers carry an
//                extra wrap bit so full and empty are told apart without a
//                separate occupancy counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    // Full: same slot, opposite lap. Empty: identical pointers.
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt state
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;

    assign o_rdata = r_mem[r_rd_ptr[c_AW-1:0]];

    // Storage array; contents need no reset because empty gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
        end
    end

    // Pointer advance; push and pop in the same cycle both take effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/reg_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_ctrl
//  Description : Buffers write requests, drives the register file write port
//                one request at a time, reads each write back and reports
//                completion plus a sticky mismatch error.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_ctrl
    import reg_wr_pkg::*;
#(
    parameter int DATA_W     = c_DATA_W,
    parameter int ADDR_W     = c_ADDR_W,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_rf_write_en,
    output logic [ADDR_W-1:0] o_rf_addr,
    output logic [DATA_W-1:0] o_rf_data,
    input  logic [DATA_W-1:0] i_rf_rdata,
    output logic              o_done_valid,
    output logic [ADDR_W-1:0] o_done_addr,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_err_addr,
    input  logic              i_err_clr,
    output logic              o_busy
);

    localparam int c_WORD_W = ADDR_W + DATA_W;

    state_e              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_done_valid;
    logic [ADDR_W-1:0]   r_done_addr;
    logic                r_err;
    logic [ADDR_W-1:0]   r_err_addr;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [c_WORD_W-1:0] w_head;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_data;
    logic                w_mismatch;

    assign o_req_ready = !w_full;
    assign w_push      = i_req_valid && !w_full;

    // A new request is taken whenever the FSM is ready to start a write
    assign w_pop       = ((r_state == ST_IDLE) || (r_state == ST_CHECK)) && !w_empty;

    assign w_head_addr = w_head[DATA_W +: ADDR_W];
    assign w_head_data = w_head[DATA_W-1:0];

    // Read-back is valid only in CHECK, one cycle after the write landed
    assign w_mismatch  = (r_state == ST_CHECK) && (i_rf_rdata != r_data);

    sync_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({i_req_addr, i_req_data}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sequencer: IDLE -> WRITE -> CHECK, chaining straight into WRITE when work remains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_done_valid <= 1'b0;
            r_done_addr  <= '0;
        end else begin
            r_done_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_WRITE;
                        r_we    <= 1'b1;
                        r_addr  <= w_head_addr;
                        r_data  <= w_head_data;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_CHECK;
                    r_we    <= 1'b0;
                end
                ST_CHECK: begin
                    // Completion is reported whether or not the read-back matched
                    r_done_valid <= 1'b1;
                    r_done_addr  <= r_addr;
                    if (w_pop) begin
                        r_state <= ST_WRITE;
                        r_we    <= 1'b1;
                        r_addr  <= w_head_addr;
                        r_data  <= w_head_data;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error keeps the first failing address; a fresh mismatch beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_mismatch && (!r_err || i_err_clr)) begin
            r_err      <= 1'b1;
            r_err_addr <= r_addr;
        end else if (i_err_clr) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end
    end

    assign o_rf_write_en = r_we;
    assign o_rf_addr     = r_addr;
    assign o_rf_data     = r_data;
    assign o_done_valid  = r_done_valid;
    assign o_done_addr   = r_done_addr;
    assign o_err         = r_err;
    assign o_err_addr    = r_err_addr;
    assign o_busy        = !w_empty || (r_state != ST_IDLE);

endmodule : reg_write_ctrl
`default_nettype wire
